// File: rtl/instr_decode_unit_if.sv
// Fetch/issue bundle between instruction memory, instr_decode_unit and Logic_Unit.
// slave is the decode unit's view; master is the view of whatever drives it.
interface instr_decode_unit_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic [7:0] Decoder;
  logic [4:0] operand;
  logic       op_valid;
  logic       stall;
  logic       jmp_en;
  logic [7:0] jmp_addr;

  modport slave (
    input  instr, instr_valid, stall, jmp_en, jmp_addr,
    output instr_ready, pc, Decoder, operand, op_valid
  );

  modport master (
    output instr, instr_valid, stall, jmp_en, jmp_addr,
    input  instr_ready, pc, Decoder, operand, op_valid
  );
endinterface

// File: rtl/instr_decode_unit.sv
// Fetch/decode front end for Logic_Unit: owns the program counter, fetches one byte per
// instruction and issues a one-hot Decoder select through a FETCH -> DECODE -> EXEC sequence.
module instr_decode_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input logic               clk,
  input logic               rst,
  instr_decode_unit_if.slave bus
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;

  logic [1:0] state;
  logic [7:0] pc_q;
  logic [7:0] ir_p0;
  logic [7:0] dec_p1;
  logic [4:0] operand_p1;
  logic       vld_p1;

  function automatic logic [7:0] onehot_op(input logic [2:0] opc);
    onehot_op = 8'b0000_0001 << opc;
  endfunction

  // Ready depends on state alone so upstream never sees a combinational loop through us.
  assign bus.instr_ready = (state == S_FETCH);
  assign bus.pc          = pc_q;
  assign bus.Decoder     = dec_p1;
  assign bus.operand     = operand_p1;
  assign bus.op_valid    = vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc_q       <= PC_RESET;
      ir_p0      <= 8'h00;
      dec_p1     <= 8'h00;
      operand_p1 <= 5'h00;
      vld_p1     <= 1'b0;
    end else begin
      if (bus.jmp_en) begin
        pc_q <= bus.jmp_addr;
      end
      case (state)
        // p0: capture the instruction byte; a jump suppresses the accept entirely.
        S_FETCH: begin
          if (!bus.jmp_en && bus.instr_valid) begin
            ir_p0 <= bus.instr;
            pc_q  <= pc_q + 8'd1;
            state <= S_DECODE;
          end
        end
        // p1: expand the opcode, unless a jump flushes the fetched byte.
        S_DECODE: begin
          if (bus.jmp_en) begin
            state <= S_FETCH;
          end else begin
            dec_p1     <= onehot_op(ir_p0[7:5]);
            operand_p1 <= ir_p0[4:0];
            vld_p1     <= 1'b1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!bus.stall) begin
            dec_p1 <= 8'h00;
            vld_p1 <= 1'b0;
            state  <= S_FETCH;
          end
        end
        default: begin
          dec_p1 <= 8'h00;
          vld_p1 <= 1'b0;
          state  <= S_FETCH;
        end
      endcase
    end
  end

endmodule
